// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   8N1 UART transmitter fed from a small byte FIFO. Bytes are pushed with a
//   valid/ready handshake and sent LSB first on ser_tx (idle high). The bit
//   period is cfg_div + 2 clock cycles. The divider is sampled into a working
//   copy whenever a frame starts, so a divider write only affects later frames.
//
// Ports
//   clock       in   system clock, all logic on rising edge
//   reset_n     in   asynchronous active-low reset
//   cfg_div_we  in   load cfg_div_in into the divider register
//   cfg_div_in  in   new divider value
//   cfg_div     out  current divider register
//   tx_data     in   byte to transmit
//   tx_valid    in   tx_data valid
//   tx_ready    out  FIFO can accept a byte
//   ser_tx      out  serial line, registered, idle high
//   busy        out  frame in progress or FIFO non-empty
//   fifo_count  out  bytes currently held in the FIFO
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 104
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          cfg_div_we,
  input  logic [DIV_WIDTH-1:0]          cfg_div_in,
  output logic [DIV_WIDTH-1:0]          cfg_div,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          ser_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  // One extra bit so div + 1 never overflows for the largest divider.
  localparam int BAUD_W = DIV_WIDTH + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // FIFO storage (data only, never reset)
  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  // Divider register and the per-frame working copy
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] div_lat_q, div_lat_d;

  // Transmit FSM
  logic [1:0]           state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic                 ser_tx_q, ser_tx_d;

  logic                 push;
  logic                 pop;
  logic                 fifo_nonempty;
  logic                 baud_last;

  assign fifo_nonempty = (count_q != '0);
  // Readiness looks only at the registered count: a pop in the same cycle
  // never frees a slot for a push when the FIFO is full.
  assign tx_ready      = (count_q < CNT_W'(FIFO_DEPTH));
  assign push          = tx_valid & tx_ready;

  // Last cycle of a bit period: counter runs 0 .. div_lat + 1 (P cycles).
  assign baud_last     = (baud_q == ({1'b0, div_lat_q} + BAUD_W'(1)));

  assign cfg_div    = div_q;
  assign ser_tx     = ser_tx_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != S_IDLE) | fifo_nonempty;

  // ---------------------------------------------------------------------------
  // FIFO pointer / count next state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointer width equals log2(depth), so increment wraps modulo depth.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  assign div_d = cfg_div_we ? cfg_div_in : div_q;

  // ---------------------------------------------------------------------------
  // Transmit FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    div_lat_d = div_lat_q;
    pop       = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (fifo_nonempty) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          div_lat_d = div_q;
          state_d   = S_START;
        end
      end

      S_START: begin
        if (baud_last) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit when data is waiting,
          // so back-to-back frames have no idle gap.
          if (fifo_nonempty) begin
            pop       = 1'b1;
            shift_d   = mem_q[rd_ptr_q];
            div_lat_d = div_q;
            state_d   = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
      end
    endcase
  end

  // Line level is derived from the current state and registered, so ser_tx
  // trails the state register by one cycle and cannot glitch.
  always_comb begin
    ser_tx_d = 1'b1;
    case (state_q)
      S_START: ser_tx_d = 1'b0;
      S_DATA:  ser_tx_d = shift_q[0];
      default: ser_tx_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      div_q     <= DIV_WIDTH'(DEFAULT_DIV);
      div_lat_q <= DIV_WIDTH'(DEFAULT_DIV);
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      ser_tx_q  <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      div_q     <= div_d;
      div_lat_q <= div_lat_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      ser_tx_q  <= ser_tx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Data registers (no reset needed: always written before being used)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo: reset defaults, single frame timing,
//   FIFO fill to full, divider change mid-frame, reset mid-frame and the
//   smallest dividers. Frames are checked sample by sample against the
//   expected 8N1 waveform.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  logic        clock;
  logic        reset_n;
  logic        cfg_div_we;
  logic [15:0] cfg_div_in;
  logic [15:0] cfg_div;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        ser_tx;
  logic        busy;
  logic [3:0]  fifo_count;

  int checks   = 0;
  int failures = 0;
  int last_wait = 0;

  uart_tx_fifo #(
    .FIFO_DEPTH  (8),
    .DIV_WIDTH   (16),
    .DEFAULT_DIV (104)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cfg_div_we (cfg_div_we),
    .cfg_div_in (cfg_div_in),
    .cfg_div    (cfg_div),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ser_tx     (ser_tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the byte is captured at the following posedge.
  task automatic push_byte(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  task automatic write_div(input logic [15:0] d);
    cfg_div_in = d;
    cfg_div_we = 1'b1;
    @(negedge clock);
    cfg_div_we = 1'b0;
  endtask

  // Waits (at most lim negedges) for the start bit, then checks every sample
  // of all ten bit periods of one frame of period p.
  task automatic expect_frame(input logic [7:0] b, input int p, input int lim, input string tag);
    int   k;
    int   bad;
    logic lvl;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (ser_tx !== 1'b0 && k < lim);
    last_wait = k;
    chk({tag, "_start_found"}, 32'(ser_tx), 32'd0);
    for (int bi = 0; bi < 10; bi++) begin
      lvl = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
      bad = 0;
      for (int c = 0; c < p; c++) begin
        if (!(bi == 0 && c == 0)) @(negedge clock);
        if (ser_tx !== lvl) bad++;
      end
      checks++;
      assert (bad === 0) else begin
        failures++;
        $error("FAIL %s_bit%0d: wrong samples=%0d expected 0 (level %b, period %0d)",
               tag, bi, bad, lvl, p);
      end
    end
  endtask

  initial begin
    int bad;
    logic [7:0] fill [9];
    fill[0] = 8'h01; fill[1] = 8'h80; fill[2] = 8'h3C;
    fill[3] = 8'hC3; fill[4] = 8'h5A; fill[5] = 8'hA5;
    fill[6] = 8'h0F; fill[7] = 8'hF0; fill[8] = 8'h99;

    reset_n    = 1'b0;
    cfg_div_we = 1'b0;
    cfg_div_in = 16'd0;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;

    // ---- 1. reset defaults ----
    repeat (3) @(negedge clock);
    chk("rst_ser_tx", 32'(ser_tx), 32'd1);
    chk("rst_cfg_div", 32'(cfg_div), 32'd104);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rel_ser_tx", 32'(ser_tx), 32'd1);
    chk("rel_tx_ready", 32'(tx_ready), 32'd1);
    chk("rel_busy", 32'(busy), 32'd0);
    chk("rel_count", 32'(fifo_count), 32'd0);
    chk("rel_cfg_div", 32'(cfg_div), 32'd104);

    // ---- 2. single byte 0x55 at P=106 ----
    push_byte(8'h55);
    expect_frame(8'h55, 106, 20, "single");
    chk("single_fall_latency", 32'(last_wait), 32'd2);
    @(negedge clock);
    chk("single_busy_after", 32'(busy), 32'd0);
    chk("single_line_idle", 32'(ser_tx), 32'd1);

    // ---- 3. fill FIFO while the line is busy ----
    fork
      begin
        for (int i = 0; i < 9; i++) begin
          tx_data  = fill[i];
          tx_valid = 1'b1;
          @(negedge clock);
        end
        chk("full_count", 32'(fifo_count), 32'd8);
        chk("full_ready", 32'(tx_ready), 32'd0);
        chk("full_busy", 32'(busy), 32'd1);
        tx_data = 8'hEE;
        @(negedge clock);
        tx_valid = 1'b0;
        chk("full_reject_count", 32'(fifo_count), 32'd8);
      end
      begin
        expect_frame(fill[0], 106, 20, "fill0");
        for (int i = 1; i < 9; i++) expect_frame(fill[i], 106, 1, "fillN");
      end
    join
    repeat (3) @(negedge clock);
    chk("fill_drained_busy", 32'(busy), 32'd0);
    chk("fill_drained_count", 32'(fifo_count), 32'd0);

    // ---- 4. divider write during bit 3 of 0xA3 ----
    fork
      begin
        push_byte(8'hA3);
        repeat (466) @(negedge clock);
        write_div(16'd10);
        chk("div_written", 32'(cfg_div), 32'd10);
        push_byte(8'h3C);
      end
      begin
        expect_frame(8'hA3, 106, 20, "divold");
        expect_frame(8'h3C, 12, 1, "divnew");
      end
    join
    repeat (2) @(negedge clock);
    chk("div_idle_busy", 32'(busy), 32'd0);

    // ---- 5. reset during DATA with three bytes queued (P=12) ----
    for (int i = 0; i < 4; i++) begin
      tx_data  = 8'h00 + 8'(i * 8'h11);
      tx_valid = 1'b1;
      @(negedge clock);
    end
    tx_valid = 1'b0;
    repeat (20) @(negedge clock);
    chk("mid_queued", 32'(fifo_count), 32'd3);
    chk("mid_data_low", 32'(ser_tx), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ser_tx", 32'(ser_tx), 32'd1);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cfg_div", 32'(cfg_div), 32'd104);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (ser_tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("mid_rst_stays_idle", 32'(bad), 32'd0);

    // ---- 6. minimum dividers ----
    write_div(16'd0);
    chk("div0_written", 32'(cfg_div), 32'd0);
    fork
      push_byte(8'h00);
      begin
        @(negedge clock);
        push_byte(8'hFF);
      end
      begin
        expect_frame(8'h00, 2, 10, "p2a");
        expect_frame(8'hFF, 2, 1, "p2b");
      end
    join
    write_div(16'd1);
    push_byte(8'h5A);
    expect_frame(8'h5A, 3, 10, "p3");
    repeat (2) @(negedge clock);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_count", 32'(fifo_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
